// File: rtl/rr_pull_arbiter.sv
// ---------------------------------------------------------------------------
// rr_pull_arbiter
//
// Round-robin arbiter merging num_src pull-style (req/ack) producer channels
// onto a single consumer port. The arbiter pulls one word at a time from the
// granted source into a one-word buffer and then offers it to the consumer.
// A per-grant timeout lets a stalled source be skipped so the others keep
// flowing.
//
// Handshake: the receiving side holds a level req; the sending side answers
// with a one-cycle ack, and data is valid in that same cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   src_en       per-source enable mask; disabled sources are never granted
//   src_req      registered one-hot pull request to the granted source
//   src_ack      one-cycle ack from a source, data valid in the same cycle
//   src_din      packed source data, slice i = [data_width*(i+1)-1 : data_width*i]
//   dst_req      consumer pull request (level)
//   dst_ack      one-cycle ack to the consumer
//   dst_dout     buffered word, valid while dst_ack is high
//   dst_src_id   index of the source that produced dst_dout
//   xfer_count   number of dst_ack pulses issued (wraps)
//   skip_count   number of grants abandoned by timeout (wraps)
// ---------------------------------------------------------------------------
module rr_pull_arbiter #(
   parameter int data_width = 32,
   parameter int num_src    = 4,
   parameter int timeout    = 16,
   localparam int IDW       = (num_src > 1) ? $clog2(num_src) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [num_src-1:0]            src_en,
   output logic [num_src-1:0]            src_req,
   input  logic [num_src-1:0]            src_ack,
   input  logic [num_src*data_width-1:0] src_din,
   input  logic                          dst_req,
   output logic                          dst_ack,
   output logic [data_width-1:0]         dst_dout,
   output logic [IDW-1:0]                dst_src_id,
   output logic [31:0]                   xfer_count,
   output logic [31:0]                   skip_count
);

   // The timeout counter only has to reach timeout-1.
   localparam int TW = (timeout > 1) ? $clog2(timeout) : 1;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      FULL
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [IDW-1:0]          ptr;
   logic [IDW-1:0]          ptr_next;
   logic [IDW-1:0]          sel;
   logic [IDW-1:0]          sel_next;
   logic [TW-1:0]           tmo;
   logic [TW-1:0]           tmo_next;
   logic [num_src-1:0]      src_req_next;
   logic                    dst_ack_next;
   logic [data_width-1:0]   dout_next;
   logic [IDW-1:0]          id_next;
   logic [31:0]             xfer_next;
   logic [31:0]             skip_next;

   logic                    scan_found;
   logic [IDW-1:0]          scan_idx;
   logic [IDW-1:0]          scan_cand;
   logic [num_src-1:0]      scan_onehot;
   logic                    tmo_expired;

   // Index increment that wraps at num_src rather than at 2^IDW, so indices
   // at or above num_src are never produced for non-power-of-two counts.
   function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
      if (int'(v) == num_src - 1) begin
         return '0;
      end
      return v + 1'b1;
   endfunction

   // Find the first enabled source starting at the round-robin pointer and
   // walking upward with wrap. The pointer itself is checked first so a
   // source that was just passed over is the last one reconsidered.
   always_comb begin
      scan_found  = 1'b0;
      scan_idx    = '0;
      scan_cand   = ptr;
      scan_onehot = '0;
      for (int k = 0; k < num_src; k++) begin
         if (!scan_found && src_en[scan_cand]) begin
            scan_found = 1'b1;
            scan_idx   = scan_cand;
         end
         scan_cand = wrap_inc(scan_cand);
      end
      scan_onehot[scan_idx] = 1'b1;
   end

   // A timeout of zero disables skipping entirely.
   always_comb begin
      tmo_expired = 1'b0;
      if (timeout != 0) begin
         tmo_expired = (tmo == TW'(timeout - 1));
      end
   end

   // Next-state and next-output logic. In FETCH an ack wins over a disable,
   // and a disable wins over a timeout, so a word arriving on the last
   // permitted cycle is still accepted. dst_ack defaults low, which limits
   // it to a single-cycle pulse.
   always_comb begin
      state_next   = state;
      ptr_next     = ptr;
      sel_next     = sel;
      tmo_next     = tmo;
      src_req_next = src_req;
      dst_ack_next = 1'b0;
      dout_next    = dst_dout;
      id_next      = dst_src_id;
      xfer_next    = xfer_count;
      skip_next    = skip_count;

      case (state)
         IDLE: begin
            src_req_next = '0;
            if (scan_found) begin
               sel_next     = scan_idx;
               src_req_next = scan_onehot;
               tmo_next     = '0;
               state_next   = FETCH;
            end
         end

         FETCH: begin
            if (src_ack[sel]) begin
               dout_next    = src_din[int'(sel)*data_width +: data_width];
               id_next      = sel;
               src_req_next = '0;
               ptr_next     = wrap_inc(sel);
               state_next   = FULL;
            end else if (!src_en[sel]) begin
               src_req_next = '0;
               ptr_next     = wrap_inc(sel);
               state_next   = IDLE;
            end else if (tmo_expired) begin
               src_req_next = '0;
               ptr_next     = wrap_inc(sel);
               skip_next    = skip_count + 32'd1;
               state_next   = IDLE;
            end else begin
               tmo_next = tmo + 1'b1;
            end
         end

         FULL: begin
            src_req_next = '0;
            if (dst_req && !dst_ack) begin
               dst_ack_next = 1'b1;
               xfer_next    = xfer_count + 32'd1;
               state_next   = IDLE;
            end
         end

         default: begin
            src_req_next = '0;
            state_next   = IDLE;
         end
      endcase
   end

   // State and output registers. Reset drops any grant in flight so no
   // late ack can be turned into a transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         sel        <= '0;
         tmo        <= '0;
         src_req    <= '0;
         dst_ack    <= 1'b0;
         dst_dout   <= '0;
         dst_src_id <= '0;
         xfer_count <= '0;
         skip_count <= '0;
      end else begin
         state      <= state_next;
         ptr        <= ptr_next;
         sel        <= sel_next;
         tmo        <= tmo_next;
         src_req    <= src_req_next;
         dst_ack    <= dst_ack_next;
         dst_dout   <= dout_next;
         dst_src_id <= id_next;
         xfer_count <= xfer_next;
         skip_count <= skip_next;
      end
   end

endmodule

// File: tb/tb_rr_pull_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_pull_arbiter
//
// Directed bench for rr_pull_arbiter (4 sources, 32-bit data, timeout 16).
// A small source model answers src_req with data 10*i+k, where k counts
// the acks source i has given so far. Its responsiveness, ack delay and a
// spurious-ack mask are adjustable per test.
// ---------------------------------------------------------------------------
module tb_rr_pull_arbiter;

   localparam int DW  = 32;
   localparam int NS  = 4;
   localparam int TMO = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NS-1:0]     src_en;
   logic [NS-1:0]     src_req;
   logic [NS-1:0]     src_ack;
   logic [NS*DW-1:0]  src_din;
   logic              dst_req;
   logic              dst_ack;
   logic [DW-1:0]     dst_dout;
   logic [1:0]        dst_src_id;
   logic [31:0]       xfer_count;
   logic [31:0]       skip_count;

   typedef struct {
      logic [NS-1:0] en;
      int            id;
      int            data;
   } vec_t;

   vec_t          vecs[12];
   int            k[NS];
   int            delay[NS];
   int            wait_cnt[NS];
   logic [NS-1:0] responsive;
   logic [NS-1:0] spurious;
   logic [NS-1:0] forbid;
   logic          prev_ack;
   int            viol_double;
   int            viol_forbid;
   int            tests;
   int            fails;

   rr_pull_arbiter #(
      .data_width(DW),
      .num_src   (NS),
      .timeout   (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .src_en    (src_en),
      .src_req   (src_req),
      .src_ack   (src_ack),
      .src_din   (src_din),
      .dst_req   (dst_req),
      .dst_ack   (dst_ack),
      .dst_dout  (dst_dout),
      .dst_src_id(dst_src_id),
      .xfer_count(xfer_count),
      .skip_count(skip_count)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One clock step: advance to the falling edge, record protocol
   // observations, then update the source model for the next rising edge.
   task automatic tick();
      logic a;
      @(negedge clk);
      if (prev_ack && dst_ack) viol_double++;
      prev_ack = dst_ack;
      if ((src_req & forbid) != '0) viol_forbid++;
      for (int i = 0; i < NS; i++) begin
         if (src_ack[i]) k[i]++;
         src_din[DW*i +: DW] = DW'(10*i + k[i]);
         a = 1'b0;
         if (src_req[i] && responsive[i]) begin
            if (wait_cnt[i] >= delay[i]) begin
               a = 1'b1;
               wait_cnt[i] = 0;
            end else begin
               wait_cnt[i]++;
            end
         end else begin
            wait_cnt[i] = 0;
         end
         src_ack[i] = a | spurious[i];
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      src_en     = '0;
      src_ack    = '0;
      dst_req    = 1'b1;
      responsive = '1;
      spurious   = '0;
      forbid     = '0;
      for (int i = 0; i < NS; i++) begin
         k[i]        = 0;
         delay[i]    = 0;
         wait_cnt[i] = 0;
      end
      tick();
      tick();
      rst      = 1'b0;
      prev_ack = 1'b0;
   endtask

   // Wait (bounded) for the next dst_ack pulse and check its payload.
   task automatic expect_xfer(input string name, input int id, input int data);
      logic ok;
      ok = 1'b0;
      for (int n = 0; n < 60; n++) begin
         tick();
         if (dst_ack) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput({name, "_arrived"}, 32'(ok), 32'd1);
      checkOutput({name, "_id"}, 32'(dst_src_id), 32'(id));
      checkOutput({name, "_data"}, dst_dout, 32'(data));
   endtask

   task automatic applyStimulus(input int r);
      src_en = vecs[r].en;
      forbid = ~vecs[r].en;
      expect_xfer($sformatf("row%0d", r), vecs[r].id, vecs[r].data);
   endtask

   initial begin
      int cnt;
      int stable_viol;
      tests       = 0;
      fails       = 0;
      viol_double = 0;
      viol_forbid = 0;
      prev_ack    = 1'b0;
      src_din     = '0;

      // All sources enabled: strict rotation 0..3, data 10*i + k.
      for (int r = 0; r < 8; r++) begin
         vecs[r].en   = 4'b1111;
         vecs[r].id   = r % 4;
         vecs[r].data = 10*(r % 4) + r/4;
      end
      // Only sources 1 and 3 enabled; each has already delivered two words.
      vecs[8]  = '{en: 4'b1010, id: 1, data: 12};
      vecs[9]  = '{en: 4'b1010, id: 3, data: 32};
      vecs[10] = '{en: 4'b1010, id: 1, data: 13};
      vecs[11] = '{en: 4'b1010, id: 3, data: 33};

      // Reset values.
      do_reset();
      tick();
      checkOutput("rst_src_req", 32'(src_req), 32'd0);
      checkOutput("rst_dst_ack", 32'(dst_ack), 32'd0);
      checkOutput("rst_dst_dout", dst_dout, 32'd0);
      checkOutput("rst_dst_src_id", 32'(dst_src_id), 32'd0);
      checkOutput("rst_xfer_count", xfer_count, 32'd0);
      checkOutput("rst_skip_count", skip_count, 32'd0);

      // Rotation and enable-mask rows.
      for (int r = 0; r < 12; r++) begin
         applyStimulus(r);
         if (r == 7) checkOutput("xfer_after_8", xfer_count, 32'd8);
      end
      checkOutput("xfer_after_12", xfer_count, 32'd12);
      checkOutput("masked_src_never_req", 32'(viol_forbid), 32'd0);

      // Stalled source 1 is skipped after exactly 16 request cycles.
      do_reset();
      src_en        = 4'b1111;
      responsive[1] = 1'b0;
      expect_xfer("t3_first", 0, 0);
      cnt = 0;
      for (int n = 0; n < 60; n++) begin
         tick();
         if (src_req[1]) cnt++;
         else if (cnt > 0) break;
      end
      checkOutput("t3_req1_cycles", 32'(cnt), 32'd16);
      checkOutput("t3_skip_count", skip_count, 32'd1);
      expect_xfer("t3_after_skip", 2, 20);
      // Source 1 now answers on the last permitted cycle.
      responsive[1] = 1'b1;
      delay[1]      = 15;
      expect_xfer("t3_next3", 3, 30);
      expect_xfer("t3_next0", 0, 1);
      expect_xfer("t3_late_ack", 1, 10);
      checkOutput("t3_skip_unchanged", skip_count, 32'd1);

      // Consumer stalls: buffer holds, no polling, then a single ack.
      do_reset();
      dst_req = 1'b0;
      src_en  = 4'b0100;
      forbid  = 4'b1011;
      repeat (5) tick();
      checkOutput("t4_held_data", dst_dout, 32'd20);
      checkOutput("t4_held_id", 32'(dst_src_id), 32'd2);
      stable_viol = 0;
      repeat (50) begin
         tick();
         if (src_req != '0 || dst_ack || dst_dout != 32'd20) stable_viol++;
      end
      checkOutput("t4_full_stable", 32'(stable_viol), 32'd0);
      dst_req = 1'b1;
      tick();
      checkOutput("t4_ack", 32'(dst_ack), 32'd1);
      checkOutput("t4_ack_data", dst_dout, 32'd20);
      checkOutput("t4_xfer_count", xfer_count, 32'd1);
      dst_req = 1'b0;
      tick();
      checkOutput("t4_ack_single", 32'(dst_ack), 32'd0);

      // Asynchronous reset in the middle of a FETCH.
      do_reset();
      src_en = 4'b1111;
      expect_xfer("t5_first", 0, 0);
      expect_xfer("t5_second", 1, 10);
      responsive[2] = 1'b0;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (src_req[2]) break;
      end
      checkOutput("t5_fetching_2", 32'(src_req), 32'd4);
      #3 rst = 1'b1;
      #1;
      checkOutput("t5_async_src_req", 32'(src_req), 32'd0);
      checkOutput("t5_async_dst_ack", 32'(dst_ack), 32'd0);
      checkOutput("t5_async_xfer", xfer_count, 32'd0);
      checkOutput("t5_async_dout", dst_dout, 32'd0);
      tick();
      rst           = 1'b0;
      responsive[2] = 1'b1;
      expect_xfer("t5_after_reset", 0, 1);

      // Spurious ack on non-granted source 2 is ignored.
      do_reset();
      src_en      = 4'b0001;
      forbid      = 4'b1110;
      delay[0]    = 3;
      spurious[2] = 1'b1;
      expect_xfer("t6_granted_0", 0, 0);
      checkOutput("t6_skip_count", skip_count, 32'd0);
      spurious = '0;
      checkOutput("no_forbidden_req", 32'(viol_forbid), 32'd0);
      checkOutput("no_double_ack", 32'(viol_double), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
